// File: rtl/cci_mem_responder_if.sv
// CCI-P request/response bundle between an AFU-side initiator (master) and the
// memory responder (slave).
interface cci_mem_responder_if #(
  parameter int unsigned CL_ADDR_WIDTH = 42,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned MDATA_WIDTH   = 16
);
  logic                     c0_tx_valid;
  logic [CL_ADDR_WIDTH-1:0] c0_tx_addr;
  logic [MDATA_WIDTH-1:0]   c0_tx_mdata;
  logic                     c0_tx_alm_full;
  logic                     c1_tx_valid;
  logic [CL_ADDR_WIDTH-1:0] c1_tx_addr;
  logic [DATA_WIDTH-1:0]    c1_tx_data;
  logic [MDATA_WIDTH-1:0]   c1_tx_mdata;
  logic                     c1_tx_alm_full;
  logic                     c0_rx_rd_valid;
  logic [DATA_WIDTH-1:0]    c0_rx_data;
  logic [MDATA_WIDTH-1:0]   c0_rx_mdata;
  logic                     c1_rx_wr_valid;
  logic [MDATA_WIDTH-1:0]   c1_rx_mdata;

  modport master (
    output c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    output c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata,
    input  c0_tx_alm_full, c1_tx_alm_full,
    input  c0_rx_rd_valid, c0_rx_data, c0_rx_mdata,
    input  c1_rx_wr_valid, c1_rx_mdata
  );

  modport slave (
    input  c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    input  c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata,
    output c0_tx_alm_full, c1_tx_alm_full,
    output c0_rx_rd_valid, c0_rx_data, c0_rx_mdata,
    output c1_rx_wr_valid, c1_rx_mdata
  );
endinterface

// File: rtl/cci_mem_responder.sv
// CCI-P host-memory responder: buffered c0 reads / c1 writes served from a cacheline RAM.
// Optional random grant stalls are enabled by defining CCI_MEM_RAND_STALL_EN.
module cci_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned CL_ADDR_WIDTH   = 42,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MDATA_WIDTH     = 16,
  parameter int unsigned RD_LATENCY      = 4,
  parameter int unsigned REQ_FIFO_DEPTH  = 16,
  parameter int unsigned ALM_FULL_THRESH = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  cci_mem_responder_if.slave bus,
  output logic             idle,
  output logic             err_ovf,
  output logic             err_addr
);
  localparam int unsigned PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(REQ_FIFO_DEPTH);
  localparam logic [PTR_W:0] ALM_LVL  = (PTR_W+1)'(REQ_FIFO_DEPTH - ALM_FULL_THRESH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  idx;
    logic [MDATA_WIDTH-1:0] mdata;
  } rd_req_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0]  data;
    logic [MDATA_WIDTH-1:0] mdata;
  } wr_req_t;

  typedef enum logic {LAST_WR, LAST_RD} arb_state_t;

  rd_req_t                rd_fifo [REQ_FIFO_DEPTH];
  wr_req_t                wr_fifo [REQ_FIFO_DEPTH];
  rd_req_t                rd_head;
  wr_req_t                wr_head;
  logic [PTR_W-1:0]       rd_wp, rd_rp, wr_wp, wr_rp;
  logic [PTR_W:0]         rd_cnt, wr_cnt, rd_cnt_nxt, wr_cnt_nxt;
  logic                   rd_push, wr_push, rd_drop, wr_drop;
  logic                   rd_grant, wr_grant, stall;
  logic                   rd_alm, wr_alm, addr_hi;
  arb_state_t             arb_q, arb_d;
  logic [DATA_WIDTH-1:0]  ram [2**ADDR_WIDTH];
  logic [RD_LATENCY-1:0]  pipe_v;
  logic [DATA_WIDTH-1:0]  pipe_d [RD_LATENCY];
  logic [MDATA_WIDTH-1:0] pipe_m [RD_LATENCY];
  logic                   ack_v;
  logic [MDATA_WIDTH-1:0] ack_m;

`ifdef CCI_MEM_RAND_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b11);
`else
  localparam logic [15:0] unused_seed = LFSR_SEED;
  assign stall = 1'b0;
`endif

  assign rd_head = rd_fifo[rd_rp];
  assign wr_head = wr_fifo[wr_rp];

  // Round-robin: with both channels pending, serve the one not served last.
  always_comb begin
    arb_d    = arb_q;
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (!stall) begin
      if (rd_cnt != '0 && (wr_cnt == '0 || arb_q == LAST_WR)) rd_grant = 1'b1;
      else if (wr_cnt != '0)                                  wr_grant = 1'b1;
    end
    if (rd_grant)      arb_d = LAST_RD;
    else if (wr_grant) arb_d = LAST_WR;
  end

  // A full FIFO still accepts a beat when its head is popped in the same cycle.
  always_comb begin
    rd_push    = bus.c0_tx_valid && (rd_cnt != FULL_LVL || rd_grant);
    wr_push    = bus.c1_tx_valid && (wr_cnt != FULL_LVL || wr_grant);
    rd_drop    = bus.c0_tx_valid && !rd_push;
    wr_drop    = bus.c1_tx_valid && !wr_push;
    rd_cnt_nxt = rd_cnt + {{PTR_W{1'b0}}, rd_push} - {{PTR_W{1'b0}}, rd_grant};
    wr_cnt_nxt = wr_cnt + {{PTR_W{1'b0}}, wr_push} - {{PTR_W{1'b0}}, wr_grant};
    addr_hi    = (bus.c0_tx_valid && (|bus.c0_tx_addr[CL_ADDR_WIDTH-1:ADDR_WIDTH])) ||
                 (bus.c1_tx_valid && (|bus.c1_tx_addr[CL_ADDR_WIDTH-1:ADDR_WIDTH]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wp    <= '0;
      rd_rp    <= '0;
      wr_wp    <= '0;
      wr_rp    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      rd_alm   <= 1'b0;
      wr_alm   <= 1'b0;
      err_ovf  <= 1'b0;
      err_addr <= 1'b0;
      arb_q    <= LAST_WR;
      ack_v    <= 1'b0;
      pipe_v   <= '0;
    end else begin
      if (rd_push)  rd_wp <= rd_wp + 1'b1;
      if (wr_push)  wr_wp <= wr_wp + 1'b1;
      if (rd_grant) rd_rp <= rd_rp + 1'b1;
      if (wr_grant) wr_rp <= wr_rp + 1'b1;
      rd_cnt <= rd_cnt_nxt;
      wr_cnt <= wr_cnt_nxt;
      rd_alm <= (rd_cnt_nxt >= ALM_LVL);
      wr_alm <= (wr_cnt_nxt >= ALM_LVL);
      if (rd_drop || wr_drop) err_ovf  <= 1'b1;
      if (addr_hi)            err_addr <= 1'b1;
      arb_q     <= arb_d;
      ack_v     <= wr_grant;
      pipe_v[0] <= rd_grant;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Storage and datapath registers carry no reset; the valids above qualify them.
  always_ff @(posedge clk) begin
    if (rd_push) rd_fifo[rd_wp] <= '{idx: bus.c0_tx_addr[ADDR_WIDTH-1:0], mdata: bus.c0_tx_mdata};
    if (wr_push) wr_fifo[wr_wp] <= '{idx: bus.c1_tx_addr[ADDR_WIDTH-1:0],
                                     data: bus.c1_tx_data, mdata: bus.c1_tx_mdata};
    if (wr_grant) begin
      ram[wr_head.idx] <= wr_head.data;
      ack_m            <= wr_head.mdata;
    end
    if (rd_grant) begin
      pipe_d[0] <= ram[rd_head.idx];
      pipe_m[0] <= rd_head.mdata;
    end
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_m[i] <= pipe_m[i-1];
    end
  end

  assign bus.c0_tx_alm_full = rd_alm;
  assign bus.c1_tx_alm_full = wr_alm;
  assign bus.c0_rx_rd_valid = pipe_v[RD_LATENCY-1];
  assign bus.c0_rx_data     = pipe_d[RD_LATENCY-1];
  assign bus.c0_rx_mdata    = pipe_m[RD_LATENCY-1];
  assign bus.c1_rx_wr_valid = ack_v;
  assign bus.c1_rx_mdata    = ack_m;
  assign idle = (rd_cnt == '0) && (wr_cnt == '0) && (pipe_v == '0);
endmodule

// File: tb/tb_cci_mem_responder.sv
// Self-checking bench for cci_mem_responder: cycle model + scoreboard plus a vector table.
module tb_cci_mem_responder;
  localparam int AW = 10, CLW = 42, DW = 512, MW = 16, RL = 4, DEPTH = 16, THR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic idle, err_ovf, err_addr;

  cci_mem_responder_if #(.CL_ADDR_WIDTH(CLW), .DATA_WIDTH(DW), .MDATA_WIDTH(MW)) bus ();

  cci_mem_responder #(
    .ADDR_WIDTH(AW), .CL_ADDR_WIDTH(CLW), .DATA_WIDTH(DW), .MDATA_WIDTH(MW),
    .RD_LATENCY(RL), .REQ_FIFO_DEPTH(DEPTH), .ALM_FULL_THRESH(THR), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .idle(idle), .err_ovf(err_ovf), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int rd_seen = 0, wr_seen = 0;
  logic [DW-1:0] last_rd_data;
  logic [MW-1:0] last_rd_mdata, last_wr_mdata;

  typedef struct { int due; logic [MW-1:0] mdata; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [AW-1:0] idx; logic [MW-1:0] mdata; logic [DW-1:0] data; } req_t;
  exp_t rd_q[$], wr_q[$];
  req_t m_rq[$], m_wq[$];
  logic [DW-1:0] m_mem [2**AW];
  bit m_last_rd = 0, m_ovf = 0, m_aerr = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on each rising edge; outputs are compared 1 time unit later.
  always begin
    bit g_rd, g_wr, exp_idle;
    req_t r;
    exp_t e;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_rq.delete(); m_wq.delete(); rd_q.delete(); wr_q.delete();
      m_last_rd = 0; m_ovf = 0; m_aerr = 0;
    end else begin
      g_rd = (m_rq.size() > 0) && (m_wq.size() == 0 || !m_last_rd);
      g_wr = !g_rd && (m_wq.size() > 0);
      if (g_rd) begin
        r = m_rq.pop_front();
        rd_q.push_back('{due: cyc + RL - 1, mdata: r.mdata, data: m_mem[r.idx]});
        m_last_rd = 1;
      end
      if (g_wr) begin
        r = m_wq.pop_front();
        m_mem[r.idx] = r.data;
        wr_q.push_back('{due: cyc, mdata: r.mdata, data: '0});
        m_last_rd = 0;
      end
      if (bus.c0_tx_valid) begin
        if (bus.c0_tx_addr[CLW-1:AW] != '0) m_aerr = 1;
        if (m_rq.size() < DEPTH)
          m_rq.push_back('{idx: bus.c0_tx_addr[AW-1:0], mdata: bus.c0_tx_mdata, data: '0});
        else m_ovf = 1;
      end
      if (bus.c1_tx_valid) begin
        if (bus.c1_tx_addr[CLW-1:AW] != '0) m_aerr = 1;
        if (m_wq.size() < DEPTH)
          m_wq.push_back('{idx: bus.c1_tx_addr[AW-1:0], mdata: bus.c1_tx_mdata, data: bus.c1_tx_data});
        else m_ovf = 1;
      end
    end
    exp_idle = (m_rq.size() == 0) && (m_wq.size() == 0) && (rd_q.size() == 0);
    #1;
    if (rst_n) begin
      check("c0_alm_full", bus.c0_tx_alm_full, m_rq.size() >= DEPTH - THR);
      check("c1_alm_full", bus.c1_tx_alm_full, m_wq.size() >= DEPTH - THR);
      check("err_ovf", err_ovf, m_ovf);
      check("err_addr", err_addr, m_aerr);
      check("idle", idle, exp_idle);
      if (rd_q.size() == 0) check("rd_spurious", bus.c0_rx_rd_valid, 1'b0);
      else if (bus.c0_rx_rd_valid) begin
        e = rd_q.pop_front();
        check("rd_latency", cyc, e.due);
        check("rd_mdata", bus.c0_rx_mdata, e.mdata);
        check("rd_data", bus.c0_rx_data, e.data);
        last_rd_data = bus.c0_rx_data; last_rd_mdata = bus.c0_rx_mdata; rd_seen++;
      end else if (rd_q[0].due <= cyc) begin
        check("rd_missing", bus.c0_rx_rd_valid, 1'b1);
        void'(rd_q.pop_front());
      end
      if (wr_q.size() == 0) check("ack_spurious", bus.c1_rx_wr_valid, 1'b0);
      else if (bus.c1_rx_wr_valid) begin
        e = wr_q.pop_front();
        check("ack_latency", cyc, e.due);
        check("ack_mdata", bus.c1_rx_mdata, e.mdata);
        last_wr_mdata = bus.c1_rx_mdata; wr_seen++;
      end else if (wr_q[0].due <= cyc) begin
        check("ack_missing", bus.c1_rx_wr_valid, 1'b1);
        void'(wr_q.pop_front());
      end
    end
  end

  // Drive one cycle of requests starting at a falling edge; returns at the next falling edge.
  task automatic beat(input bit rv, input logic [CLW-1:0] ra, input logic [MW-1:0] rm,
                      input bit wv, input logic [CLW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [MW-1:0] wm);
    bus.c0_tx_valid = rv; bus.c0_tx_addr = ra; bus.c0_tx_mdata = rm;
    bus.c1_tx_valid = wv; bus.c1_tx_addr = wa; bus.c1_tx_data = wd; bus.c1_tx_mdata = wm;
    @(negedge clk);
    bus.c0_tx_valid = 1'b0; bus.c1_tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((m_rq.size() + m_wq.size() + rd_q.size() + wr_q.size()) != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check({tag, "_drain_timeout"}, n < 300, 1'b1);
    check({tag, "_idle_after"}, idle, 1'b1);
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  typedef struct {
    bit wr; logic [CLW-1:0] addr; logic [7:0] b; logic [MW-1:0] mdata;
    logic [7:0] exp_b; bit exp_err;
  } vec_t;
  vec_t vec [11];

  initial begin
    int base, n;
    logic [DW-1:0] d;
    vec[0]  = '{1, 42'd5,           8'hA5, 16'd3,  8'h00, 0};
    vec[1]  = '{0, 42'd5,           8'h00, 16'd7,  8'hA5, 0};
    vec[2]  = '{1, 42'd0,           8'h3C, 16'd1,  8'h00, 0};
    vec[3]  = '{1, 42'd1023,        8'h5A, 16'd2,  8'h00, 0};
    vec[4]  = '{0, 42'd1023,        8'h00, 16'd4,  8'h5A, 0};
    vec[5]  = '{0, 42'd0,           8'h00, 16'd6,  8'h3C, 0};
    vec[6]  = '{1, 42'd5,           8'h11, 16'd8,  8'h00, 0};
    vec[7]  = '{0, 42'd5,           8'h00, 16'd9,  8'h11, 0};
    vec[8]  = '{0, 42'h400,         8'h00, 16'd10, 8'h3C, 1};
    vec[9]  = '{1, 42'h300_0000_0005, 8'h99, 16'd11, 8'h00, 1};
    vec[10] = '{0, 42'd5,           8'h00, 16'd12, 8'h99, 1};

    bus.c0_tx_valid = 1'b0; bus.c0_tx_addr = '0; bus.c0_tx_mdata = '0;
    bus.c1_tx_valid = 1'b0; bus.c1_tx_addr = '0; bus.c1_tx_data = '0; bus.c1_tx_mdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rd_valid", bus.c0_rx_rd_valid, 1'b0);
    check("reset_wr_valid", bus.c1_rx_wr_valid, 1'b0);
    check("reset_c0_alm", bus.c0_tx_alm_full, 1'b0);
    check("reset_c1_alm", bus.c1_tx_alm_full, 1'b0);
    check("reset_err_ovf", err_ovf, 1'b0);
    check("reset_err_addr", err_addr, 1'b0);
    check("reset_idle", idle, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vec[i].wr) begin
        base = wr_seen;
        beat(0, '0, '0, 1, vec[i].addr, {64{vec[i].b}}, vec[i].mdata);
        n = 0;
        while (wr_seen == base && n < 20) begin @(negedge clk); n++; end
        check("vec_ack_arrived", wr_seen > base, 1'b1);
        check("vec_ack_mdata", last_wr_mdata, vec[i].mdata);
      end else begin
        base = rd_seen;
        beat(1, vec[i].addr, vec[i].mdata, 0, '0, '0, '0);
        n = 0;
        while (rd_seen == base && n < 20) begin @(negedge clk); n++; end
        check("vec_rd_arrived", rd_seen > base, 1'b1);
        check("vec_rd_data", last_rd_data, {64{vec[i].exp_b}});
        check("vec_rd_mdata", last_rd_mdata, vec[i].mdata);
      end
      check("vec_err_addr", err_addr, vec[i].exp_err);
    end
    drain("table");

    // Read issued the cycle after a write to the same line must see the new data.
    base = rd_seen;
    beat(0, '0, '0, 1, 42'd7, {64{8'hEE}}, 16'h77);
    beat(1, 42'd7, 16'h70, 0, '0, '0, '0);
    drain("raw");
    check("raw_rd_count", rd_seen - base, 1);
    check("raw_new_data", last_rd_data, {64{8'hEE}});

    for (int i = 0; i < 32; i++) beat(0, '0, '0, 1, CLW'(i), {16{32'hC0DE_0000 + 32'(i)}}, MW'(i));
    drain("prefill");

    base = rd_seen;
    for (int i = 0; i < 16; i++) beat(1, CLW'(i), MW'(i), 0, '0, '0, '0);
    drain("burst16");
    check("burst16_count", rd_seen - base, 16);
    check("burst16_last_mdata", last_rd_mdata, 16'd15);
    check("burst16_last_data", last_rd_data, {16{32'hC0DE_000F}});
    check("burst16_no_ovf", err_ovf, 1'b1 & m_ovf);

    base = rd_seen;
    n = wr_seen;
    for (int i = 0; i < 4; i++)
      beat(1, CLW'(16 + i), MW'(16'h40 + i), 1, CLW'(32 + i), rnd_line(), MW'(16'h50 + i));
    drain("rr4");
    check("rr4_rd_count", rd_seen - base, 4);
    check("rr4_ack_count", wr_seen - n, 4);

    for (int c = 0; c < 300; c++) begin
      d = rnd_line();
      beat(($urandom_range(0, 1) == 1) && !bus.c0_tx_alm_full, CLW'($urandom_range(0, 35)),
           MW'($urandom()),
           ($urandom_range(0, 1) == 1) && !bus.c1_tx_alm_full, CLW'($urandom_range(0, 35)),
           d, MW'($urandom()));
    end
    drain("random");

    for (int i = 0; i < 40; i++)
      beat(1, CLW'(i % 32), MW'(16'h100 + i), 1, CLW'(i % 32), rnd_line(), MW'(16'h200 + i));
    check("ovf_set", err_ovf, 1'b1);
    drain("ovf");
    check("ovf_sticky", err_ovf, 1'b1);

    for (int i = 0; i < 3; i++) beat(1, CLW'(i), MW'(16'h60 + i), 0, '0, '0, '0);
    @(negedge clk);
    check("rst_pre_busy", idle, 1'b0);
    base = rd_seen;
    rst_n = 1'b0;
    #1;
    check("rst_rd_valid", bus.c0_rx_rd_valid, 1'b0);
    check("rst_wr_valid", bus.c1_rx_wr_valid, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_err_ovf_clear", err_ovf, 1'b0);
    check("rst_err_addr_clear", err_addr, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_late_rsp", rd_seen, base);
    check("rst_idle_after", idle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
